// File: rtl/x_mem_rv32i_pkg.sv
// Shared types and constants for the RV32I word-wide memory responder.
package x_mem_rv32i_pkg;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;
  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_MMIO} src_t;

  localparam int WAIT_W = 4;

  localparam logic [31:0] MMIO_GPIO_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_CNT_ADDR  = 32'hFFFF_FFF4;

  // Byte lane bits are ignored when decoding a word address.
  function automatic logic word_match(input logic [31:0] a, input logic [31:0] base);
    return (a & ~32'h3) == (base & ~32'h3);
  endfunction

endpackage

// File: rtl/x_mem_rv32i_ram.sv
// Single-port synchronous word RAM with registered, read-enabled output.
module x_mem_rv32i_ram #(
  parameter int AW = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    if (i_re) o_rdata <= mem[i_addr];
  end

endmodule

// File: rtl/x_mem_rv32i_resp.sv
// Memory responder for the RV32I request bus with WAIT wait states.
// Optional GPIO/cycle-counter MMIO words enabled by X_MEM_RV32I_RESP_MMIO_EN.
module x_mem_rv32i_resp
  import x_mem_rv32i_pkg::*;
#(
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_valid,
  input  logic          i_rnw,
  input  logic [31:0]   i_addr,
  input  logic [31:0]   i_data,
  output logic          o_accept,
  output logic [31:0]   o_data,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [31:0]   i_ld_data,
`ifdef X_MEM_RV32I_RESP_MMIO_EN
  output logic [31:0]   o_gpio,
`endif
  output logic          o_err
);

  localparam logic [WAIT_W-1:0] WAIT_CNT = WAIT_W'(WAIT);

  state_t            state, state_n;
  logic [WAIT_W-1:0] cnt, cnt_n;
  src_t              src_p0, src_n;
  logic              issue, ram_hit, in_range;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = ^i_addr[1:0];
  assign issue   = (state == S_IDLE) && i_valid && !i_ld_en;
  assign ram_hit = (i_addr[31:AW+2] == '0);

`ifdef X_MEM_RV32I_RESP_MMIO_EN
  logic        gpio_hit, cyc_hit;
  logic [31:0] cycles, mmio_p0;

  assign gpio_hit = word_match(i_addr, MMIO_GPIO_ADDR);
  assign cyc_hit  = word_match(i_addr, MMIO_CNT_ADDR);
  assign in_range = ram_hit || gpio_hit || cyc_hit;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_gpio <= '0;
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
      if (issue && !i_rnw && gpio_hit) o_gpio <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (issue) mmio_p0 <= gpio_hit ? o_gpio : cycles;
  end
`else
  assign in_range = ram_hit;
`endif

  // Load port owns the RAM whenever it strobes; issue is already blocked then.
  assign ram_we    = i_ld_en || (issue && !i_rnw && ram_hit);
  assign ram_re    = issue && i_rnw && ram_hit;
  assign ram_addr  = i_ld_en ? i_ld_addr : i_addr[AW+1:2];
  assign ram_wdata = i_ld_en ? i_ld_data : i_data;

  x_mem_rv32i_ram #(.AW(AW)) u_ram (
    .i_clk   (i_clk),
    .i_we    (ram_we),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    src_n = SRC_ZERO;
    if (i_rnw && ram_hit) src_n = SRC_RAM;
`ifdef X_MEM_RV32I_RESP_MMIO_EN
    if (i_rnw && (gpio_hit || cyc_hit)) src_n = SRC_MMIO;
`endif
  end

  // Stage p0: request captured at issue
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      src_p0 <= SRC_ZERO;
      o_err  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (issue) begin
        src_p0 <= src_n;
        if (!in_range) o_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        if (issue) begin
          cnt_n   = WAIT_CNT;
          state_n = (WAIT_CNT != '0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_n = cnt - WAIT_W'(1);
        if (cnt == WAIT_W'(1)) state_n = S_ACK;
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_accept = (state == S_ACK);

  always_comb begin
    o_data = '0;
    if (state == S_ACK) begin
      case (src_p0)
        SRC_RAM:  o_data = ram_rdata;
`ifdef X_MEM_RV32I_RESP_MMIO_EN
        SRC_MMIO: o_data = mmio_p0;
`endif
        default:  o_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_x_mem_rv32i_resp.sv
// Randomised bench for x_mem_rv32i_resp: two instances (WAIT=0 and WAIT=3) against a queue model.
module tb_x_mem_rv32i_resp;

  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int BIG   = 32'h7fff_ffff;

  typedef struct {
    int          acc;
    logic [31:0] data;
    bit          dc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int WT = (g == 0) ? 0 : 3;

    logic          nrst, valid, rnw, ld_en, accept, err;
    logic [31:0]   addr, wdata, rdata, ld_data;
    logic [AW-1:0] ld_addr;
`ifdef X_MEM_RV32I_RESP_MMIO_EN
    logic [31:0]   gpio;
`endif

    x_mem_rv32i_resp #(.AW(AW), .WAIT(WT)) dut (
      .i_clk     (clk),
      .i_nrst    (nrst),
      .i_valid   (valid),
      .i_rnw     (rnw),
      .i_addr    (addr),
      .i_data    (wdata),
      .o_accept  (accept),
      .o_data    (rdata),
      .i_ld_en   (ld_en),
      .i_ld_addr (ld_addr),
      .i_ld_data (ld_data),
`ifdef X_MEM_RV32I_RESP_MMIO_EN
      .o_gpio    (gpio),
`endif
      .o_err     (err)
    );

    exp_t        q[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] gpio_m;
    int          idle_from, err_cyc, last_acc, n_acc;
    logic [31:0] last_data;
    bit          fin = 1'b0;

    // Per-cycle comparison against the model
    always @(negedge clk) begin : cmp
      string p;
      bit    ea;
      #1;
      p = $sformatf("w%0d_", WT);
      if (!nrst) begin
        check({p, "rst_accept"}, 32'(accept), 32'd0);
        check({p, "rst_data"}, rdata, 32'd0);
        check({p, "rst_err"}, 32'(err), 32'd0);
      end else begin
        ea = 1'b0;
        if (q.size() > 0) ea = (q[0].acc == cyc);
        check({p, "accept"}, 32'(accept), 32'(ea));
        if (accept) begin
          last_acc  = cyc;
          last_data = rdata;
          n_acc++;
        end
        if (ea) begin
          if (!q[0].dc) check({p, "rdata"}, rdata, q[0].data);
          void'(q.pop_front());
        end
        check({p, "err"}, 32'(err), 32'(cyc >= err_cyc));
`ifdef X_MEM_RV32I_RESP_MMIO_EN
        if (q.size() == 0) check({p, "gpio"}, gpio, gpio_m);
`endif
      end
    end

    // Model: returns the word the request must produce and applies its side effects.
    task automatic model_req(input bit r, input logic [31:0] a, input logic [31:0] d,
                             input int start, inout bit dc, output logic [31:0] ed);
      ed = '0;
      if (a[31:AW+2] == '0) begin
        if (r) ed = mdl_mem[a[AW+1:2]];
        else   mdl_mem[a[AW+1:2]] = d;
      end
`ifdef X_MEM_RV32I_RESP_MMIO_EN
      else if (a[31:2] == 30'h3FFF_FFFC) begin
        if (r) ed = gpio_m;
        else   gpio_m = d;
      end else if (a[31:2] == 30'h3FFF_FFFD) begin
        dc = r;
      end
`endif
      else if (err_cyc > start + 1) begin
        err_cyc = start + 1;
      end
    endtask

    task automatic req(input bit r, input logic [31:0] a, input logic [31:0] d, input bit dc_in);
      exp_t e;
      int   start;
      bit   dc;
      dc    = dc_in;
      start = (cyc > idle_from) ? cyc : idle_from;
      model_req(r, a, d, start, dc, e.data);
      e.acc = start + 1 + WT;
      e.dc  = dc;
      q.push_back(e);
      idle_from = e.acc + 1;
      valid = 1'b1; rnw = r; addr = a; wdata = d;
      while (cyc < e.acc) @(negedge clk);
      #2;
    endtask

    task automatic idle(input int n);
      valid = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
      nrst = 1'b0; valid = 1'b0; ld_en = 1'b0;
      q.delete();
      err_cyc = BIG;
      gpio_m  = '0;
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      idle_from = cyc;
    endtask

    // Read of word idx 9 while the load port rewrites that word mid-flight.
    task automatic rd_with_load(input logic [31:0] nv);
      exp_t e;
      bit   dc;
      dc = 1'b0;
      model_req(1'b1, 32'h24, 32'h0, cyc, dc, e.data);
      e.acc = cyc + 1 + WT; e.dc = 1'b0;
      q.push_back(e);
      idle_from = e.acc + 1;
      valid = 1'b1; rnw = 1'b1; addr = 32'h24;
      @(negedge clk);
      ld_en = 1'b1; ld_addr = AW'(9); ld_data = nv; mdl_mem[9] = nv;
      if (cyc >= e.acc) valid = 1'b0;
      @(negedge clk);
      ld_en = 1'b0;
      if (cyc >= e.acc) valid = 1'b0;
      while (cyc < e.acc) @(negedge clk);
      valid = 1'b0;
      #2;
    endtask

    initial begin : drv
      int          c0, na0;
      logic [31:0] v1, v2, a, d;
      string       p;
      p = $sformatf("w%0d_", WT);
      nrst = 1'b0; valid = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      err_cyc = BIG; idle_from = 0; gpio_m = '0; last_acc = 0; n_acc = 0; last_data = '0;
      do_reset();

      for (int i = 0; i < DEPTH; i++) begin
        ld_en = 1'b1; ld_addr = AW'(i);
        ld_data = (i == 0) ? 32'h0000_0013 : $urandom;
        mdl_mem[i] = ld_data;
        @(negedge clk);
      end
      ld_en = 1'b0;
      idle(1);

      c0 = cyc;
      req(1'b1, 32'h0, 32'h0, 1'b0);
      check({p, "boot_word"}, last_data, 32'h0000_0013);
      check({p, "read_latency"}, 32'(last_acc - c0), 32'(1 + WT));
      idle(1);

      c0 = cyc;
      req(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
      check({p, "store_latency"}, 32'(last_acc - c0), 32'(1 + WT));
      c0 = cyc;
      req(1'b1, 32'h10, 32'h0, 1'b0);
      check({p, "store_readback"}, last_data, 32'hDEAD_BEEF);
      check({p, "b2b_latency"}, 32'(last_acc - (c0 + 1)), 32'(1 + WT));
      idle(1);

      na0 = n_acc;
      req(1'b0, 32'h30, 32'hCAFE_0001, 1'b0);
      req(1'b1, 32'h30, 32'h0, 1'b0);
      idle(4);
      check({p, "held_valid_accepts"}, 32'(n_acc - na0), 32'd2);
      check({p, "held_valid_data"}, last_data, 32'hCAFE_0001);

      valid = 1'b1; rnw = 1'b1; addr = 32'h20;
      ld_en = 1'b1; ld_addr = AW'(8); ld_data = 32'h0BAD_F00D; mdl_mem[8] = 32'h0BAD_F00D;
      repeat (2) @(negedge clk);
      ld_en = 1'b0;
      req(1'b1, 32'h20, 32'h0, 1'b0);
      check({p, "ld_priority"}, last_data, 32'h0BAD_F00D);
      idle(1);

      v1 = mdl_mem[9];
      rd_with_load(32'h7777_0009);
      check({p, "inflight_capture"}, last_data, v1);
      idle(1);
      req(1'b1, 32'h24, 32'h0, 1'b0);
      idle(1);

      valid = 1'b1; rnw = 1'b1; addr = 32'h10;
      repeat (WT / 2) @(negedge clk);
      do_reset();
      idle(3);
      req(1'b1, 32'h10, 32'h0, 1'b0);
      check({p, "after_reset"}, last_data, 32'hDEAD_BEEF);
      idle(1);

`ifdef X_MEM_RV32I_RESP_MMIO_EN
      req(1'b0, 32'hFFFF_FFF0, 32'h0000_005A, 1'b0);
      idle(2);
      check({p, "gpio_lit"}, gpio, 32'h0000_005A);
      req(1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0);
      idle(1);
      req(1'b0, 32'hFFFF_FFF4, 32'h1234_5678, 1'b0);
      idle(1);
      req(1'b1, 32'hFFFF_FFF4, 32'h0, 1'b1);
      v1 = last_data;
      req(1'b1, 32'hFFFF_FFF4, 32'h0, 1'b1);
      v2 = last_data;
      idle(1);
      check({p, "cnt_delta"}, v2 - v1, 32'(WT + 2));
`endif

      for (int i = 0; i < 80; i++) begin
        int gap;
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
        d = $urandom;
        req(1'($urandom_range(0, 1)), a, d, 1'b0);
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(gap);
      end
      idle(1);

      req(1'b1, 32'h0001_0000, 32'h0, 1'b0);
      check({p, "oor_data"}, last_data, 32'h0);
      idle(2);
      req(1'b0, 32'h0002_0040, 32'h1234_5678, 1'b0);
      idle(1);
      req(1'b1, 32'h40, 32'h0, 1'b0);
      idle(3);
      check({p, "err_sticky"}, 32'(err), 32'd1);
      do_reset();
      idle(2);
      check({p, "err_cleared"}, 32'(err), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin : summary
    for (int t = 0; t < 200000 && !(gi[0].fin && gi[1].fin); t++) @(negedge clk);
    n_tests++;
    if (!(gi[0].fin && gi[1].fin)) begin
      n_fail++;
      $display("FAIL timeout: done flags %0b%0b, expected 11", gi[1].fin, gi[0].fin);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
